// File: rtl/pong_pkg.sv
// Shared pong definitions: bounce codes, winner codes and referee FSM states.
package pong_pkg;

    typedef enum logic [1:0] {
        BOUNCE_NONE   = 2'd0,
        BOUNCE_PADDLE = 2'd1,
        BOUNCE_WALL   = 2'd2,
        BOUNCE_GOAL   = 2'd3
    } bounce_t;

    typedef enum logic [1:0] {
        WINNER_NONE = 2'd0,
        WINNER_P1   = 2'd1,
        WINNER_P2   = 2'd2
    } winner_t;

    typedef enum logic [1:0] {
        ST_PLAY    = 2'd0,
        ST_HOLDOFF = 2'd1,
        ST_SERVE   = 2'd2,
        ST_OVER    = 2'd3
    } ref_state_t;

endpackage

// File: rtl/rect_overlap.sv
// Combinational ball-versus-paddle rectangle test; edges that touch count as a hit.
// All sums are one bit wider than a position so they cannot wrap.
module rect_overlap #(
    parameter int POS_W  = 10,
    parameter int SIZE_W = 8
) (
    input  logic [POS_W-1:0]  ball_x,
    input  logic [POS_W-1:0]  ball_y,
    input  logic [SIZE_W-1:0] ball_size_x,
    input  logic [SIZE_W-1:0] ball_size_y,
    input  logic [POS_W-1:0]  rect_x,
    input  logic [POS_W-1:0]  rect_y,
    input  logic [SIZE_W-1:0] rect_size_x,
    input  logic [SIZE_W-1:0] rect_size_y,
    output logic              hit
);

    localparam int PAD_W = POS_W + 1 - SIZE_W;

    logic [POS_W:0] ball_x_ext;
    logic [POS_W:0] ball_y_ext;
    logic [POS_W:0] rect_x_ext;
    logic [POS_W:0] rect_y_ext;
    logic [POS_W:0] ball_right;
    logic [POS_W:0] ball_bottom;
    logic [POS_W:0] rect_right;
    logic [POS_W:0] rect_bottom;

    assign ball_x_ext  = {1'b0, ball_x};
    assign ball_y_ext  = {1'b0, ball_y};
    assign rect_x_ext  = {1'b0, rect_x};
    assign rect_y_ext  = {1'b0, rect_y};
    assign ball_right  = ball_x_ext + {{PAD_W{1'b0}}, ball_size_x};
    assign ball_bottom = ball_y_ext + {{PAD_W{1'b0}}, ball_size_y};
    assign rect_right  = rect_x_ext + {{PAD_W{1'b0}}, rect_size_x};
    assign rect_bottom = rect_y_ext + {{PAD_W{1'b0}}, rect_size_y};

    // Overlap on both axes at once.
    always_comb begin
        hit = (ball_x_ext <= rect_right) && (ball_right >= rect_x_ext) &&
              (ball_y_ext <= rect_bottom) && (ball_bottom >= rect_y_ext);
    end

endmodule

// File: rtl/collision_referee.sv
// Pong referee: classifies the ball position once per frame, emits a one-cycle
// bounce strobe, keeps score and decides the winner.
module collision_referee
    import pong_pkg::*;
#(
    parameter int SCREEN_X       = 640,
    parameter int SCREEN_Y       = 480,
    parameter int MARGIN         = 5,
    parameter int POS_W          = 10,
    parameter int SIZE_W         = 8,
    parameter int SCORE_W        = 4,
    parameter int WIN_SCORE      = 9,
    parameter int HOLDOFF_FRAMES = 4,
    parameter int SERVE_FRAMES   = 60
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               new_game,
    input  logic [POS_W-1:0]   ball_pos_x,
    input  logic [POS_W-1:0]   ball_pos_y,
    input  logic [SIZE_W-1:0]  ball_size_x,
    input  logic [SIZE_W-1:0]  ball_size_y,
    input  logic [POS_W-1:0]   paddle_1_pos_x,
    input  logic [POS_W-1:0]   paddle_1_pos_y,
    input  logic [POS_W-1:0]   paddle_2_pos_x,
    input  logic [POS_W-1:0]   paddle_2_pos_y,
    input  logic [SIZE_W-1:0]  paddle_1_size_x,
    input  logic [SIZE_W-1:0]  paddle_1_size_y,
    input  logic [SIZE_W-1:0]  paddle_2_size_x,
    input  logic [SIZE_W-1:0]  paddle_2_size_y,
    output logic [1:0]         bounce,
    output logic               bounce_valid,
    output logic [SCORE_W-1:0] score_player_1,
    output logic [SCORE_W-1:0] score_player_2,
    output logic               game_over,
    output logic [1:0]         winner
);

    if (WIN_SCORE > (1 << SCORE_W) - 1) begin : g_bad_win_score
        $error("WIN_SCORE does not fit in SCORE_W bits");
    end

    localparam int MAX_FRAMES = (SERVE_FRAMES > HOLDOFF_FRAMES) ? SERVE_FRAMES : HOLDOFF_FRAMES;
    localparam int CNT_W      = $clog2(MAX_FRAMES + 1);
    localparam int PAD_W      = POS_W + 1 - SIZE_W;

    localparam logic [POS_W:0]   GOAL_RIGHT  = (POS_W+1)'(SCREEN_X - MARGIN);
    localparam logic [POS_W:0]   WALL_BOTTOM = (POS_W+1)'(SCREEN_Y - MARGIN);
    localparam logic [POS_W:0]   EDGE_LOW    = (POS_W+1)'(MARGIN);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLDOFF_FRAMES - 1);
    localparam logic [CNT_W-1:0] SERVE_LAST  = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL   = SCORE_W'(WIN_SCORE);

    ref_state_t         state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [SCORE_W-1:0] score_1, score_1_next, score_2, score_2_next;
    logic               over, over_next;
    winner_t            winner_q, winner_next;
    bounce_t            bounce_q, bounce_next;
    logic               valid_q, valid_next;

    logic [POS_W:0]     ball_right, ball_bottom;
    logic               goal_right, goal_left, wall_bottom, wall_top;
    logic               hit_1, hit_2;
    logic [SCORE_W-1:0] score_1_inc, score_2_inc;

    assign ball_right  = {1'b0, ball_pos_x} + {{PAD_W{1'b0}}, ball_size_x};
    assign ball_bottom = {1'b0, ball_pos_y} + {{PAD_W{1'b0}}, ball_size_y};
    assign goal_right  = ball_right >= GOAL_RIGHT;
    assign goal_left   = {1'b0, ball_pos_x} <= EDGE_LOW;
    assign wall_bottom = ball_bottom >= WALL_BOTTOM;
    assign wall_top    = {1'b0, ball_pos_y} <= EDGE_LOW;
    assign score_1_inc = score_1 + SCORE_W'(1);
    assign score_2_inc = score_2 + SCORE_W'(1);

    rect_overlap #(.POS_W(POS_W), .SIZE_W(SIZE_W)) u_paddle_1 (
        .ball_x      (ball_pos_x),
        .ball_y      (ball_pos_y),
        .ball_size_x (ball_size_x),
        .ball_size_y (ball_size_y),
        .rect_x      (paddle_1_pos_x),
        .rect_y      (paddle_1_pos_y),
        .rect_size_x (paddle_1_size_x),
        .rect_size_y (paddle_1_size_y),
        .hit         (hit_1)
    );

    rect_overlap #(.POS_W(POS_W), .SIZE_W(SIZE_W)) u_paddle_2 (
        .ball_x      (ball_pos_x),
        .ball_y      (ball_pos_y),
        .ball_size_x (ball_size_x),
        .ball_size_y (ball_size_y),
        .rect_x      (paddle_2_pos_x),
        .rect_y      (paddle_2_pos_y),
        .rect_size_x (paddle_2_size_x),
        .rect_size_y (paddle_2_size_y),
        .hit         (hit_2)
    );

    // Next-state, score and event decode; new_game overrides any frame_tick.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        score_1_next = score_1;
        score_2_next = score_2;
        over_next    = over;
        winner_next  = winner_q;
        bounce_next  = BOUNCE_NONE;
        valid_next   = 1'b0;
        if (new_game) begin
            state_next   = ST_SERVE;
            cnt_next     = '0;
            score_1_next = '0;
            score_2_next = '0;
            over_next    = 1'b0;
            winner_next  = WINNER_NONE;
        end else if (frame_tick) begin
            case (state)
                ST_PLAY, ST_HOLDOFF: begin
                    if (goal_right || goal_left) begin
                        bounce_next = BOUNCE_GOAL;
                        valid_next  = 1'b1;
                        cnt_next    = '0;
                        state_next  = ST_SERVE;
                        if (goal_right) begin
                            score_1_next = score_1_inc;
                            if (score_1_inc == WIN_VAL) begin
                                state_next  = ST_OVER;
                                over_next   = 1'b1;
                                winner_next = WINNER_P1;
                            end
                        end else begin
                            score_2_next = score_2_inc;
                            if (score_2_inc == WIN_VAL) begin
                                state_next  = ST_OVER;
                                over_next   = 1'b1;
                                winner_next = WINNER_P2;
                            end
                        end
                    end else if (state == ST_PLAY) begin
                        if (wall_bottom || wall_top || hit_1 || hit_2) begin
                            bounce_next = (wall_bottom || wall_top) ? BOUNCE_WALL : BOUNCE_PADDLE;
                            valid_next  = 1'b1;
                            state_next  = ST_HOLDOFF;
                            cnt_next    = '0;
                        end
                    end else if (cnt == HOLD_LAST) begin
                        state_next = ST_PLAY;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                ST_SERVE: begin
                    if (cnt == SERVE_LAST) begin
                        state_next = ST_PLAY;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State, counters, scores and the registered event strobe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_SERVE;
            cnt      <= '0;
            score_1  <= '0;
            score_2  <= '0;
            over     <= 1'b0;
            winner_q <= WINNER_NONE;
            bounce_q <= BOUNCE_NONE;
            valid_q  <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            score_1  <= score_1_next;
            score_2  <= score_2_next;
            over     <= over_next;
            winner_q <= winner_next;
            bounce_q <= bounce_next;
            valid_q  <= valid_next;
        end
    end

    assign bounce         = bounce_q;
    assign bounce_valid   = valid_q;
    assign score_player_1 = score_1;
    assign score_player_2 = score_2;
    assign game_over      = over;
    assign winner         = winner_q;

endmodule

// File: doc/collision_referee.md
COLLISION_REFEREE -- requirements
Module: collision_referee

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- SCREEN_X, 640, screen width in pixels
- SCREEN_Y, 480, screen height in pixels
- MARGIN, 5, edge band in pixels that counts as wall or goal
- POS_W, 10, position width
- SIZE_W, 8, size width
- SCORE_W, 4, score counter width
- WIN_SCORE, 9, points to win
- HOLDOFF_FRAMES, 4, frames suppressed after a bounce
- SERVE_FRAMES, 60, frames to wait after a goal

REQ-002 The block SHALL have these ports (name  direction  width  meaning):
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- frame_tick  in  1  one-cycle pulse, once per video frame
- new_game  in  1  one-cycle pulse, restart match
- ball_pos_x, ball_pos_y  in  POS_W  ball top-left corner
- ball_size_x, ball_size_y  in  SIZE_W  ball size
- paddle_1_pos_x/_y, paddle_2_pos_x/_y  in  POS_W  paddle top-left corners
- paddle_1_size_x/_y, paddle_2_size_x/_y  in  SIZE_W  paddle sizes
- bounce  out  2  0 none, 1 paddle, 2 wall, 3 goal
- bounce_valid  out  1  one-cycle event strobe
- score_player_1, score_player_2  out  SCORE_W  scores
- game_over  out  1  match finished
- winner  out  2  0 none, 1 player 1, 2 player 2

Function
REQ-003 Geometry SHALL be evaluated only in a cycle where frame_tick=1; the result SHALL be registered, with bounce_valid=1 on the next cycle only, for exactly one cycle.
REQ-004 All sums (pos+size) SHALL be computed at POS_W+1 bits, so no wrap-around occurs.
REQ-005 Detection priority SHALL be: goal right (ball_x+size_x >= SCREEN_X-MARGIN, player 1 scores) > goal left (ball_x <= MARGIN, player 2 scores) > bottom wall (ball_y+size_y >= SCREEN_Y-MARGIN) > top wall (ball_y <= MARGIN) > paddle 1 > paddle 2.
REQ-006 A paddle hit SHALL require full rectangle overlap: ball_x <= px+psx, ball_x+bsx >= px, ball_y <= py+psy, and ball_y+bsy >= py.
REQ-007 When bounce_valid=0, bounce SHALL read 0.
REQ-008 The FSM SHALL have four states: PLAY, HOLDOFF, SERVE, OVER.
REQ-009 In PLAY, a wall or paddle event SHALL be emitted and the FSM SHALL enter HOLDOFF with the frame counter cleared.
REQ-010 In HOLDOFF, wall and paddle events SHALL be suppressed but goals SHALL still be evaluated.
REQ-011 HOLDOFF SHALL return to PLAY after HOLDOFF_FRAMES frame_ticks.
REQ-012 On a goal in PLAY or HOLDOFF, the block SHALL emit bounce=3 and increment the scoring player's counter.
REQ-013 After a goal, if the new score equals WIN_SCORE the FSM SHALL enter OVER, set game_over=1 and set winner; otherwise it SHALL enter SERVE.
REQ-014 In SERVE, no events SHALL be emitted; the FSM SHALL return to PLAY after SERVE_FRAMES frame_ticks.
REQ-015 In OVER, no events SHALL be emitted, and scores, game_over and winner SHALL hold.
REQ-016 A new_game pulse in any state SHALL clear scores, game_over, winner and the frame counter, and enter SERVE.
REQ-017 A frame_tick coinciding with new_game SHALL be ignored.
REQ-018 Scores SHALL never exceed WIN_SCORE; WIN_SCORE SHALL be at most 2^SCORE_W-1.

Reset
REQ-019 On reset, the FSM SHALL go to SERVE, and the frame counter, bounce, bounce_valid, both scores, game_over and winner SHALL all be 0, asynchronously.
REQ-020 A reset asserted mid-HOLDOFF or mid-SERVE SHALL abandon the count, and no pending event strobe SHALL be emitted after release.

Structure
REQ-021 The bounce codes (NONE/PADDLE/WALL/GOAL), the winner codes and the FSM state encodings SHALL live in the shared pong package, for reuse by ball_fsm.
REQ-022 One sub-module, rect_overlap, SHALL implement the combinational paddle test of REQ-006 and SHALL be instantiated twice.

Verification
REQ-023 Wall: ball (300,3), size 8x8, tick -> next cycle bounce=2, bounce_valid=1; a second tick at the same position within 4 frames -> no strobe.
REQ-024 Goal: ball_x=630, size_x 8, tick -> bounce=3, score_player_1=1, FSM enters SERVE; ticks during the next 60 frames -> no strobe.
REQ-025 Priority: ball (2,2) touching goal left and top wall -> bounce=3, score_player_2 increments.
REQ-026 Paddle: paddle_1 (20,200) size 8x64, ball (25,230) -> bounce=1; ball (40,230), behind-edge miss -> no event.
REQ-027 Win: score_player_2=8, left goal -> score 9, game_over=1, winner=2; further ticks -> no strobe; new_game -> scores 0, game_over=0.
REQ-028 Reset asserted mid-HOLDOFF, with and without a tick in flight -> all outputs 0 immediately; after release, first strobe only after SERVE_FRAMES ticks.
